coefficient_loader: RTL and testbench

Receiving end of the FIR coefficient setup stream. Accepts signed coefficients one per cycle from the coefficient source, writes them in order into a LENGTH-entry register bank, and flags when a complete set is present. The filter taps read the bank through a flattened parallel bus and a random-access read port.

---
 rtl/coefficient_loader_if.sv | 24 ++
 rtl/coefficient_loader.sv | 97 +++++++++
 tb/tb_coefficient_loader.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/coefficient_loader_if.sv
// Coefficient setup stream between the coefficient source (master) and the loader (slave).
// The source drives the request and data; the loader answers with ready.
interface coefficient_loader_if #(
  parameter int DATA_WIDTH = 8
);
  logic                         enable;
  logic                         coefficient_valid;
  logic signed [DATA_WIDTH-1:0] coefficient_in;
  logic                         ready;

  modport master (
    output enable,
    output coefficient_valid,
    output coefficient_in,
    input  ready
  );

  modport slave (
    input  enable,
    input  coefficient_valid,
    input  coefficient_in,
    output ready
  );
endinterface

// File: rtl/coefficient_loader.sv
// Loads a full set of signed FIR coefficients, in index order, into a register bank.
// The bank is exposed as a flattened bus and through a random-access read port.
module coefficient_loader #(
  parameter int LENGTH     = 20,
  parameter int DATA_WIDTH = 8
) (
  input  logic                           clock,
  input  logic                           reset,
  coefficient_loader_if.slave            stream,
  output logic                           filterSetFlag,
  output logic                           loadDone,
  input  logic [$clog2(LENGTH)-1:0]      rd_addr,
  output logic signed [DATA_WIDTH-1:0]   rd_data,
  output logic [LENGTH*DATA_WIDTH-1:0]   coefficients_out
);

  localparam int AW = $clog2(LENGTH);
  localparam int IW = $clog2(LENGTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                       state;
  logic [IW-1:0]                idx;
  logic signed [DATA_WIDTH-1:0] coefficients [LENGTH];

  // An enable in LOAD restarts the set; a beat on that same edge becomes entry 0.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      idx           <= '0;
      filterSetFlag <= 1'b0;
      loadDone      <= 1'b0;
      for (int k = 0; k < LENGTH; k++) begin
        coefficients[k] <= '0;
      end
    end else begin
      loadDone <= 1'b0;
      case (state)
        IDLE: begin
          if (stream.enable) begin
            state         <= LOAD;
            idx           <= '0;
            filterSetFlag <= 1'b0;
          end
        end
        LOAD: begin
          if (stream.enable) begin
            if (stream.coefficient_valid) begin
              coefficients[0] <= stream.coefficient_in;
              idx             <= IW'(1);
            end else begin
              idx <= '0;
            end
          end else if (stream.coefficient_valid) begin
            coefficients[idx[AW-1:0]] <= stream.coefficient_in;
            idx                       <= idx + IW'(1);
            if (idx == IW'(LENGTH - 1)) begin
              state         <= DONE;
              loadDone      <= 1'b1;
              filterSetFlag <= 1'b1;
            end
          end
        end
        DONE: begin
          if (stream.enable) begin
            state         <= LOAD;
            idx           <= '0;
            filterSetFlag <= 1'b0;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign stream.ready = (state == LOAD);

  always_comb begin
    rd_data = '0;
    if (32'(rd_addr) < LENGTH) begin
      rd_data = coefficients[rd_addr];
    end
  end

  for (genvar k = 0; k < LENGTH; k++) begin : g_flatten
    assign coefficients_out[k*DATA_WIDTH +: DATA_WIDTH] = coefficients[k];
  end

endmodule

// File: tb/tb_coefficient_loader.sv
// Directed testbench for coefficient_loader: reset, streaming, gaps, ignored beats,
// restart, async reset mid-load and direct DONE-to-LOAD reload.
module tb_coefficient_loader;

  localparam int LENGTH = 20;
  localparam int DW     = 8;

  logic                   clock = 1'b0;
  logic                   reset = 1'b1;
  logic                   filterSetFlag;
  logic                   loadDone;
  logic [4:0]             rd_addr;
  logic signed [DW-1:0]   rd_data;
  logic [LENGTH*DW-1:0]   coefficients_out;

  int compared   = 0;
  int mismatched = 0;

  int vals [20] = '{34, 34, 0, 49, 125, -77, -51, 8, 97, 109,
                    -91, -3, 9, 1, 59, 75, 19, 58, -97, 10};
  logic [LENGTH*DW-1:0] expBank;
  logic [LENGTH*DW-1:0] valsBank;

  coefficient_loader_if #(.DATA_WIDTH(DW)) stream ();

  coefficient_loader #(
    .LENGTH(LENGTH),
    .DATA_WIDTH(DW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .stream(stream),
    .filterSetFlag(filterSetFlag),
    .loadDone(loadDone),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .coefficients_out(coefficients_out)
  );

  always #5 clock = ~clock;

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  // Drives enable for one edge, then the vals stream back-to-back; returns in the DONE cycle.
  task automatic loadVals;
    stream.enable = 1'b1;
    step();
    stream.enable = 1'b0;
    for (int i = 0; i < LENGTH; i++) begin
      stream.coefficient_valid = 1'b1;
      stream.coefficient_in    = 8'(vals[i]);
      step();
    end
    stream.coefficient_valid = 1'b0;
  endtask

  task automatic test_reset;
    stream.enable            = 1'b0;
    stream.coefficient_valid = 1'b0;
    stream.coefficient_in    = '0;
    rd_addr                  = 5'd0;
    reset                    = 1'b1;
    repeat (2) step();
    compared++; if (stream.ready !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_ready: got %b expected 0", stream.ready); end
    compared++; if (filterSetFlag !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_flag: got %b expected 0", filterSetFlag); end
    compared++; if (loadDone !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_loadDone: got %b expected 0", loadDone); end
    compared++; if (coefficients_out !== '0) begin mismatched++; $display("[TB] FAIL reset_bank: got %h expected 0", coefficients_out); end
    compared++; if (rd_data !== 8'h00) begin mismatched++; $display("[TB] FAIL reset_rd_data: got %h expected 00", rd_data); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_back_to_back;
    int pulses = 0;
    stream.enable = 1'b1;
    step();
    compared++; if (stream.ready !== 1'b1) begin mismatched++; $display("[TB] FAIL b2b_ready_after_enable: got %b expected 1", stream.ready); end
    stream.enable = 1'b0;
    for (int i = 0; i < LENGTH; i++) begin
      stream.coefficient_valid = 1'b1;
      stream.coefficient_in    = 8'(vals[i]);
      step();
      if (loadDone === 1'b1) pulses++;
    end
    stream.coefficient_valid = 1'b0;
    compared++; if (loadDone !== 1'b1) begin mismatched++; $display("[TB] FAIL b2b_loadDone_at_20: got %b expected 1", loadDone); end
    compared++; if (filterSetFlag !== 1'b1) begin mismatched++; $display("[TB] FAIL b2b_flag: got %b expected 1", filterSetFlag); end
    compared++; if (stream.ready !== 1'b0) begin mismatched++; $display("[TB] FAIL b2b_ready_done: got %b expected 0", stream.ready); end
    step();
    compared++; if (loadDone !== 1'b0) begin mismatched++; $display("[TB] FAIL b2b_loadDone_width: got %b expected 0", loadDone); end
    compared++; if (pulses !== 1) begin mismatched++; $display("[TB] FAIL b2b_pulse_count: got %0d expected 1", pulses); end
    rd_addr = 5'd5;
    #1;
    compared++; if (rd_data !== 8'hB3) begin mismatched++; $display("[TB] FAIL b2b_rd5: got %h expected b3", rd_data); end
    compared++; if (coefficients_out[7:0] !== 8'd34) begin mismatched++; $display("[TB] FAIL b2b_low_byte: got %h expected 22", coefficients_out[7:0]); end
    compared++; if (coefficients_out[159:152] !== 8'd10) begin mismatched++; $display("[TB] FAIL b2b_top_byte: got %h expected 0a", coefficients_out[159:152]); end
    compared++; if (coefficients_out !== valsBank) begin mismatched++; $display("[TB] FAIL b2b_bank: got %h expected %h", coefficients_out, valsBank); end
  endtask

  task automatic test_gaps;
    int pulses = 0;
    int beats  = 0;
    reset = 1'b1;
    #1;
    reset = 1'b0;
    compared++; if (coefficients_out !== '0) begin mismatched++; $display("[TB] FAIL gaps_cleared: got %h expected 0", coefficients_out); end
    stream.enable = 1'b1;
    step();
    stream.enable = 1'b0;
    for (int c = 0; c < 39; c++) begin
      stream.coefficient_valid = (c % 2 == 0);
      stream.coefficient_in    = (c % 2 == 0) ? 8'(vals[c/2]) : 8'h5A;
      step();
      if (c % 2 == 0) beats++;
      if (loadDone === 1'b1) pulses++;
      if (c < 38) begin
        compared++; if (dut.idx !== 5'(beats)) begin mismatched++; $display("[TB] FAIL gaps_idx_c%0d: got %0d expected %0d", c, dut.idx, beats); end
      end
    end
    stream.coefficient_valid = 1'b0;
    compared++; if (loadDone !== 1'b1) begin mismatched++; $display("[TB] FAIL gaps_loadDone_at_39: got %b expected 1", loadDone); end
    step();
    compared++; if (pulses !== 1) begin mismatched++; $display("[TB] FAIL gaps_pulse_count: got %0d expected 1", pulses); end
    compared++; if (coefficients_out !== valsBank) begin mismatched++; $display("[TB] FAIL gaps_bank: got %h expected %h", coefficients_out, valsBank); end
  endtask

  task automatic test_ignore;
    stream.coefficient_valid = 1'b1;
    stream.coefficient_in    = 8'd55;
    repeat (3) begin
      step();
      compared++; if (stream.ready !== 1'b0) begin mismatched++; $display("[TB] FAIL idle_ready: got %b expected 0", stream.ready); end
      compared++; if (filterSetFlag !== 1'b1) begin mismatched++; $display("[TB] FAIL idle_flag: got %b expected 1", filterSetFlag); end
    end
    compared++; if (coefficients_out !== valsBank) begin mismatched++; $display("[TB] FAIL idle_bank: got %h expected %h", coefficients_out, valsBank); end
    stream.coefficient_valid = 1'b0;
    loadVals();
    stream.coefficient_valid = 1'b1;
    stream.coefficient_in    = 8'd55;
    step();
    step();
    stream.coefficient_valid = 1'b0;
    compared++; if (coefficients_out !== valsBank) begin mismatched++; $display("[TB] FAIL done_bank: got %h expected %h", coefficients_out, valsBank); end
    compared++; if (filterSetFlag !== 1'b1) begin mismatched++; $display("[TB] FAIL done_flag: got %b expected 1", filterSetFlag); end
    compared++; if (loadDone !== 1'b0) begin mismatched++; $display("[TB] FAIL done_loadDone: got %b expected 0", loadDone); end
    compared++; if (stream.ready !== 1'b0) begin mismatched++; $display("[TB] FAIL done_ready: got %b expected 0", stream.ready); end
  endtask

  task automatic test_restart;
    int pulses = 0;
    stream.enable = 1'b1;
    step();
    compared++; if (filterSetFlag !== 1'b0) begin mismatched++; $display("[TB] FAIL restart_flag_clear: got %b expected 0", filterSetFlag); end
    stream.enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      stream.coefficient_valid = 1'b1;
      stream.coefficient_in    = 8'd7;
      step();
    end
    stream.coefficient_valid = 1'b0;
    compared++; if (coefficients_out[79:72] !== 8'd7) begin mismatched++; $display("[TB] FAIL restart_entry9: got %h expected 07", coefficients_out[79:72]); end
    compared++; if (coefficients_out[87:80] !== 8'hA5) begin mismatched++; $display("[TB] FAIL restart_entry10_kept: got %h expected a5", coefficients_out[87:80]); end
    stream.enable            = 1'b1;
    stream.coefficient_valid = 1'b1;
    stream.coefficient_in    = 8'd0;
    step();
    stream.enable = 1'b0;
    compared++; if (stream.ready !== 1'b1) begin mismatched++; $display("[TB] FAIL restart_ready: got %b expected 1", stream.ready); end
    for (int k = 1; k < LENGTH; k++) begin
      stream.coefficient_in = 8'(k);
      step();
      if (loadDone === 1'b1) pulses++;
      compared++; if (filterSetFlag !== (k == LENGTH - 1)) begin mismatched++; $display("[TB] FAIL restart_flag_k%0d: got %b expected %b", k, filterSetFlag, (k == LENGTH - 1)); end
    end
    stream.coefficient_valid = 1'b0;
    step();
    for (int k = 0; k < LENGTH; k++) expBank[k*DW +: DW] = 8'(k);
    compared++; if (pulses !== 1) begin mismatched++; $display("[TB] FAIL restart_pulse_count: got %0d expected 1", pulses); end
    compared++; if (coefficients_out !== expBank) begin mismatched++; $display("[TB] FAIL restart_bank: got %h expected %h", coefficients_out, expBank); end
  endtask

  task automatic test_reset_mid;
    stream.enable = 1'b1;
    step();
    stream.enable = 1'b0;
    for (int i = 0; i < 12; i++) begin
      stream.coefficient_valid = 1'b1;
      stream.coefficient_in    = 8'(vals[i]);
      step();
    end
    #2;
    reset = 1'b1;
    #1;
    compared++; if (stream.ready !== 1'b0) begin mismatched++; $display("[TB] FAIL midreset_ready: got %b expected 0", stream.ready); end
    compared++; if (filterSetFlag !== 1'b0) begin mismatched++; $display("[TB] FAIL midreset_flag: got %b expected 0", filterSetFlag); end
    compared++; if (loadDone !== 1'b0) begin mismatched++; $display("[TB] FAIL midreset_loadDone: got %b expected 0", loadDone); end
    compared++; if (coefficients_out !== '0) begin mismatched++; $display("[TB] FAIL midreset_bank: got %h expected 0", coefficients_out); end
    rd_addr = 5'd25;
    #1;
    compared++; if (rd_data !== 8'h00) begin mismatched++; $display("[TB] FAIL midreset_rd25: got %h expected 00", rd_data); end
    rd_addr = 5'd3;
    #1;
    compared++; if (rd_data !== 8'h00) begin mismatched++; $display("[TB] FAIL midreset_rd3: got %h expected 00", rd_data); end
    stream.coefficient_valid = 1'b0;
    step();
    reset = 1'b0;
    repeat (3) step();
    compared++; if (loadDone !== 1'b0) begin mismatched++; $display("[TB] FAIL midreset_no_done: got %b expected 0", loadDone); end
    compared++; if (stream.ready !== 1'b0) begin mismatched++; $display("[TB] FAIL midreset_idle: got %b expected 0", stream.ready); end
  endtask

  task automatic test_direct_reload;
    loadVals();
    compared++; if (loadDone !== 1'b1) begin mismatched++; $display("[TB] FAIL direct_first_done: got %b expected 1", loadDone); end
    stream.enable = 1'b1;
    step();
    stream.enable = 1'b0;
    compared++; if (stream.ready !== 1'b1) begin mismatched++; $display("[TB] FAIL direct_ready: got %b expected 1", stream.ready); end
    compared++; if (filterSetFlag !== 1'b0) begin mismatched++; $display("[TB] FAIL direct_flag_drop: got %b expected 0", filterSetFlag); end
    compared++; if (loadDone !== 1'b0) begin mismatched++; $display("[TB] FAIL direct_loadDone_low: got %b expected 0", loadDone); end
    for (int k = 0; k < LENGTH; k++) begin
      stream.coefficient_valid = 1'b1;
      stream.coefficient_in    = 8'(3 * k - 30);
      expBank[k*DW +: DW]      = 8'(3 * k - 30);
      step();
    end
    stream.coefficient_valid = 1'b0;
    compared++; if (loadDone !== 1'b1) begin mismatched++; $display("[TB] FAIL direct_second_done: got %b expected 1", loadDone); end
    step();
    compared++; if (coefficients_out !== expBank) begin mismatched++; $display("[TB] FAIL direct_bank: got %h expected %h", coefficients_out, expBank); end
    compared++; if (filterSetFlag !== 1'b1) begin mismatched++; $display("[TB] FAIL direct_flag_set: got %b expected 1", filterSetFlag); end
    #2;
    reset = 1'b1;
    #1;
    compared++; if (filterSetFlag !== 1'b0) begin mismatched++; $display("[TB] FAIL direct_reset_flag: got %b expected 0", filterSetFlag); end
    step();
    reset = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < LENGTH; k++) valsBank[k*DW +: DW] = 8'(vals[k]);
    expBank = '0;
    test_reset();
    test_back_to_back();
    test_gaps();
    test_ignore();
    test_restart();
    test_reset_mid();
    test_direct_reload();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
